// File: rtl/inv_kin_pkg.sv
// inv_kin_pkg: Q-format constants, CORDIC angle ROM and FSM states shared by inv_kin_2j
package inv_kin_pkg;
  localparam int BIT_WIDTH = 32;
  localparam int FRACTIONS = 15;
  localparam int IW = 34;
  localparam logic signed [IW-1:0] K = 34'sd19899;
  localparam logic signed [IW-1:0] ONE = 34'sd32768;
  localparam logic signed [IW-1:0] PI = 34'sd102944;
  localparam logic signed [IW-1:0] PI_2 = 34'sd51472;
  typedef enum logic [2:0] {CAP, VEC1, PREP, SQRT, VEC2, OUT} state_e;
  function automatic logic signed [IW-1:0] atan_rom(input logic [3:0] i);
    case (i)
      4'd0: return 34'sd25736;
      4'd1: return 34'sd15193;
      4'd2: return 34'sd8027;
      4'd3: return 34'sd4075;
      4'd4: return 34'sd2045;
      4'd5: return 34'sd1024;
      4'd6: return 34'sd512;
      4'd7: return 34'sd256;
      4'd8: return 34'sd128;
      4'd9: return 34'sd64;
      4'd10: return 34'sd32;
      4'd11: return 34'sd16;
      4'd12: return 34'sd8;
      4'd13: return 34'sd4;
      4'd14: return 34'sd2;
      default: return 34'sd1;
    endcase
  endfunction
endpackage

// File: rtl/inv_kin_cordic_vec.sv
// inv_kin_cordic_vec: 16-step iterative vectoring CORDIC returning magnitude (gain ~1.6468) and angle
// Ports: clock, rst (async, active-low); start loads x_in/y_in and runs step 0 in the same cycle;
// mag/ang hold the result once done (high during the final step) has been seen.
module inv_kin_cordic_vec
  import inv_kin_pkg::*;
(
  input  logic                 clock,
  input  logic                 rst,
  input  logic                 start,
  input  logic signed [IW-1:0] x_in,
  input  logic signed [IW-1:0] y_in,
  output logic signed [IW-1:0] mag,
  output logic signed [IW-1:0] ang,
  output logic                 done
);
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, z_q, z_d, xs, ys, zs;
  logic [3:0] i_q, i_d, i;
  logic busy_q, busy_d, flip, neg;
  always_comb begin
    flip = start && x_in[IW-1];
    neg = y_in[IW-1];
    // left half-plane: pre-rotate by -/+ pi/2 so the iterations only cover +/- 1.74 rad
    xs = !start ? x_q : flip ? (neg ? -y_in : y_in) : x_in;
    ys = !start ? y_q : flip ? (neg ? x_in : -x_in) : y_in;
    zs = !start ? z_q : flip ? (neg ? -PI_2 : PI_2) : '0;
    i = start ? 4'd0 : i_q;
    x_d = ys[IW-1] ? xs - (ys >>> i) : xs + (ys >>> i);
    y_d = ys[IW-1] ? ys + (xs >>> i) : ys - (xs >>> i);
    z_d = ys[IW-1] ? zs - atan_rom(i) : zs + atan_rom(i);
    i_d = i + 4'd1;
    busy_d = start || (busy_q && i_q != 4'd15);
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      i_q <= '0;
      busy_q <= 1'b0;
    end else if (start || busy_q) begin
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      i_q <= i_d;
      busy_q <= busy_d;
    end
  assign mag = x_q;
  assign ang = z_q;
  assign done = busy_q && i_q == 4'd15;
endmodule

// File: rtl/inv_kin_2j.sv
// inv_kin_2j: free-running inverse kinematics for a 2-joint planar arm with L1 = L2 = 0.5
// Ports: x, y target (Q17.15); theta1 shoulder, theta2 elbow (Q17.15 rad, registered);
// clock; rst async active-low. One result every 51 cycles.
// INV_KIN_ELBOW_UP_EN selects the elbow-up solution (theta2 <= 0).
module inv_kin_2j #(
  parameter int BIT_WIDTH = inv_kin_pkg::BIT_WIDTH,
  parameter int FRACTIONS = inv_kin_pkg::FRACTIONS
) (
  input  logic signed [BIT_WIDTH-1:0] x,
  input  logic signed [BIT_WIDTH-1:0] y,
  output logic signed [BIT_WIDTH-1:0] theta1,
  output logic signed [BIT_WIDTH-1:0] theta2,
  input  logic                        clock,
  input  logic                        rst
);
  import inv_kin_pkg::*;
  state_e state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic signed [IW-1:0] x_q, x_d, y_q, y_d, phi_q, phi_d, r_q, r_d;
  logic [31:0] rad_q, rad_d;
  logic [17:0] rem_q, rem_d;
  logic [15:0] root_q, root_d;
  logic signed [BIT_WIDTH-1:0] theta1_q, theta1_d, theta2_q, theta2_d;
  logic signed [IW-1:0] cv_x, cv_y, cv_mag, cv_ang, r_raw, r_c, q, alpha, t1, t2;
  logic signed [2*IW-1:0] prod_k, sq;
  logic [19:0] rem_t, trial;
  logic cv_start, cv_done, ge;
  inv_kin_cordic_vec u_cordic (
    .clock(clock),
    .rst(rst),
    .start(cv_start),
    .x_in(cv_x),
    .y_in(cv_y),
    .mag(cv_mag),
    .ang(cv_ang),
    .done(cv_done)
  );
  always_comb begin
    cv_start = (state_q == VEC1 || state_q == VEC2) && cnt_q == 4'd0;
    cv_x = state_q == VEC1 ? x_q : r_q;
    cv_y = state_q == VEC1 ? y_q : IW'(root_q);
    state_d = state_q == CAP ? VEC1 :
              state_q == VEC1 ? (cv_done ? PREP : VEC1) :
              state_q == PREP ? SQRT :
              state_q == SQRT ? (cnt_q == 4'd15 ? VEC2 : SQRT) :
              state_q == VEC2 ? (cv_done ? OUT : VEC2) : CAP;
    // 16-cycle phases wrap the counter back to 0 on their last edge
    cnt_d = (state_q == VEC1 || state_q == SQRT || state_q == VEC2) ? cnt_q + 4'd1 : 4'd0;
    x_d = state_q == CAP ? IW'(x) : x_q;
    y_d = state_q == CAP ? IW'(y) : y_q;
    prod_k = cv_mag * K;
    r_raw = IW'(prod_k >>> FRACTIONS);
    r_c = r_raw >= ONE ? ONE : r_raw;
    sq = r_c * r_c;
    q = ONE - IW'(sq >>> FRACTIONS);
    // atan2(0, 0) is defined as 0; the CORDIC would otherwise sum the whole ROM
    phi_d = state_q != PREP ? phi_q : (x_q == '0 && y_q == '0) ? '0 : cv_ang > PI ? PI : cv_ang;
    r_d = state_q == PREP ? r_c : r_q;
    // restoring square root of q << 15 gives sqrt(q) directly in Q15
    rem_t = {rem_q, rad_q[31:30]};
    trial = {2'b00, root_q, 2'b01};
    ge = rem_t >= trial;
    rad_d = state_q == PREP ? 32'(q) << FRACTIONS : state_q == SQRT ? rad_q << 2 : rad_q;
    rem_d = state_q == PREP ? '0 : state_q == SQRT ? (ge ? 18'(rem_t - trial) : 18'(rem_t)) : rem_q;
    root_d = state_q == PREP ? '0 : state_q == SQRT ? {root_q[14:0], ge} : root_q;
    // truncation can leave the angle a few LSB outside [0, pi/2]
    alpha = cv_ang < 0 ? '0 : cv_ang > PI_2 ? PI_2 : cv_ang;
`ifdef INV_KIN_ELBOW_UP_EN
    t1 = phi_q + alpha;
    t2 = -(alpha <<< 1);
`else
    t1 = phi_q - alpha;
    t2 = alpha <<< 1;
`endif
    theta1_d = state_q == OUT ? BIT_WIDTH'(t1) : theta1_q;
    theta2_d = state_q == OUT ? BIT_WIDTH'(t2) : theta2_q;
  end
  always_ff @(posedge clock or negedge rst)
    if (!rst) begin
      state_q <= CAP;
      cnt_q <= '0;
      x_q <= '0;
      y_q <= '0;
      phi_q <= '0;
      r_q <= '0;
      rad_q <= '0;
      rem_q <= '0;
      root_q <= '0;
      theta1_q <= '0;
      theta2_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      x_q <= x_d;
      y_q <= y_d;
      phi_q <= phi_d;
      r_q <= r_d;
      rad_q <= rad_d;
      rem_q <= rem_d;
      root_q <= root_d;
      theta1_q <= theta1_d;
      theta2_q <= theta2_d;
    end
  assign theta1 = theta1_q;
  assign theta2 = theta2_q;
endmodule

// File: tb/tb_inv_kin_2j.sv
// tb_inv_kin_2j: directed and random checks of inv_kin_2j latency, reset and joint angles
module tb_inv_kin_2j;
  logic clock = 1'b0;
  logic rst;
  logic signed [31:0] x, y, theta1, theta2;
  int n_run = 0;
  int n_fail = 0;
  always #5 clock = ~clock;
  inv_kin_2j dut (
    .x(x),
    .y(y),
    .theta1(theta1),
    .theta2(theta2),
    .clock(clock),
    .rst(rst)
  );
  task automatic check(input string tag, input longint obs, input longint exp, input longint tol);
    n_run++;
    if (obs > exp + tol || obs < exp - tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, obs, exp, tol);
    end
  endtask
  function automatic longint exp_t1(input longint phi, input longint al);
`ifdef INV_KIN_ELBOW_UP_EN
    return phi + al;
`else
    return phi - al;
`endif
  endfunction
  function automatic longint exp_t2(input longint al);
`ifdef INV_KIN_ELBOW_UP_EN
    return -2 * al;
`else
    return 2 * al;
`endif
  endfunction
  task automatic vec(input string tag, input int xi, input int yi, input longint phi, input longint al, input longint tol2, input int wait_cyc);
    x = xi;
    y = yi;
    repeat (wait_cyc) @(posedge clock);
    #1;
    check({tag, "_t1"}, theta1, exp_t1(phi, al), 16);
    check({tag, "_t2"}, theta2, exp_t2(al), tol2);
  endtask
  task automatic rnd(input string tag, input int xi, input int yi);
    real xr, yr, r, phi;
    xr = real'(xi) / 32768.0;
    yr = real'(yi) / 32768.0;
    phi = (xi == 0 && yi == 0) ? 0.0 : $atan2(yr, xr);
    r = $sqrt(xr * xr + yr * yr);
    if (r > 1.0) r = 1.0;
    vec(tag, xi, yi, longint'(phi * 32768.0), longint'($acos(r) * 32768.0), 16, 500);
  endtask
  initial begin
    int nz, nx, m;
    rst = 1'b0;
    x = 16384;
    y = 16384;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_t1", theta1, 0, 0);
    check("rst_t2", theta2, 0, 0);
    rst = 1'b1;
    nz = 0;
    nx = 0;
    for (int e = 1; e <= 50; e++) begin
      @(posedge clock);
      #1;
      if (theta1 != 0 || theta2 != 0) nz++;
      if ($isunknown({theta1, theta2})) nx++;
    end
    check("zero_before_51", nz, 0, 0);
    check("no_x", nx, 0, 0);
    @(posedge clock);
    #1;
    check("first_t1", theta1, exp_t1(25736, 25736), 16);
    check("first_t2", theta2, exp_t2(25736), 16);
    repeat (39) @(posedge clock);
    #1;
    check("hold_t2", theta2, exp_t2(25736), 16);
    rst = 1'b0;
    #1;
    check("midrst_t1", theta1, 0, 0);
    check("midrst_t2", theta2, 0, 0);
    @(negedge clock);
    rst = 1'b1;
    vec("x1_y0", 32768, 0, 0, 0, 16, 110);
    vec("x0_yh", 0, 16384, 51472, 34315, 16, 110);
    vec("x0_ynh", 0, -16384, -51472, 34315, 16, 110);
    vec("xh_yh", 16384, 16384, 25736, 25736, 16, 110);
    vec("xm1_y0", -32768, 0, 102944, 0, 16, 110);
    vec("x2_far", 65536, 0, 0, 0, 0, 110);
    void'($urandom(32'd7));
    for (int k = 0; k < 4; k++) rnd("rnd32", int'($urandom()), int'($urandom()));
    for (int k = 0; k < 4; k++) begin
      m = int'($urandom_range(16384, 4096));
      nz = int'($urandom_range(16384, 4096));
      rnd("rnd_reach", $urandom_range(1, 0) == 1 ? -m : m, $urandom_range(1, 0) == 1 ? -nz : nz);
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule

// File: doc/inv_kin_2j.md
# inv_kin_2j

Fixed-point inverse-kinematics solver for a planar two-joint arm with equal link lengths L1 = L2 = 0.5. It continuously samples a target point (x, y) and produces the joint angles theta1 (shoulder) and theta2 (elbow). Results are in radians. The block is free-running: there is no request/acknowledge handshake. It sits behind the trajectory stimulus and feeds the joint-angle consumers, which sample its outputs at a much lower rate.

## Interface
- BIT_WIDTH, default 32: word width of all data ports.
- FRACTIONS, default 15: fractional bits; all ports are signed two's-complement Q17.15.
- clock, input, 1: single clock; all logic is rising-edge.
- rst, input, 1: reset; one clock; reset is asynchronous and active-low.
- x, input, BIT_WIDTH: target x coordinate, Q17.15.
- y, input, BIT_WIDTH: target y coordinate, Q17.15.
- theta1, output, BIT_WIDTH: shoulder angle in radians, Q17.15, registered.
- theta2, output, BIT_WIDTH: elbow angle in radians, Q17.15, registered.
- Port order: x, y, theta1, theta2, clock, rst.

## Operation
- Math (valid because L1 = L2):
  - r = sqrt(x²+y²); phi = atan2(y, x); alpha = acos(min(r, 1)).
  - theta2 = 2·alpha; theta1 = phi − alpha.
- FSM states: CAP → VEC1 → PREP → SQRT → VEC2 → OUT → CAP, repeating forever.
- CAP: register x and y, sign-extended to 34-bit internal words (2 guard bits).
- VEC1: 16 CORDIC vectoring iterations on (x, y).
  - Quadrant pre-rotation: if x < 0, rotate ±π/2 (sign chosen by y) and seed z = ±π/2.
  - Result: phi in (−π, π]; atan2(0, 0) = 0.
- PREP:
  - Scale magnitude by K = 19899 (0.60725, Q15) to get r.
  - If r ≥ 1.0, set r = 1.0 (unreachable target → arm fully stretched).
  - Compute q = 1 − r² (Q15, one multiplier).
- SQRT: 16-iteration restoring bit-serial square root, s = sqrt(q).
- VEC2: CORDIC vectoring on (r, s). Its angle output is alpha in [0, π/2].
- OUT: theta2 = alpha << 1; theta1 = phi − alpha. Both are registered.
- Arithmetic: arithmetic shifts, truncation (no rounding). Results fit in 32 bits, so no output saturation is needed.
- Inputs may change at any time. Only the value present at the CAP edge is used.

## Timing
- Reset asserted: FSM goes to CAP; theta1 = 0, theta2 = 0; all datapath registers cleared.
- Cycle budget: CAP 1, VEC1 16, PREP 1, SQRT 16, VEC2 16, OUT 1. Period = 51 cycles.
- Outputs update on the OUT edge, 50 cycles after the CAP edge that sampled x and y. They hold until the next OUT edge.
- First valid result: 51 rising edges after rst deasserts. Outputs stay 0 until then.
- Reset asserted mid-computation: the result in progress is discarded and outputs return to 0 immediately.
- Accuracy: within ±16 LSB of the ideal double-precision result for any input.

## Configuration
- INV_KIN_ELBOW_UP_EN defined: elbow-up solution, theta2 = −2·alpha and theta1 = phi + alpha.
- Undefined (default): elbow-down solution as specified above (theta2 ≥ 0).
- Latency is identical in both builds.

## Structure
- Package inv_kin_pkg holds:
  - Q-format constants: BIT_WIDTH, FRACTIONS, internal width 34.
  - CORDIC gain K = 19899.
  - ONE = 32768, PI = 102944, PI_2 = 51472.
  - The 16-entry atan(2^-i) ROM in Q17.15: 25736, 15193, 8027, 4075, 2045, …, 1.
  - The FSM state enum.
- One sub-module, inv_kin_cordic_vec: iterative 16-step vectoring CORDIC with start/done, shared by VEC1 and VEC2.
- The square root and FSM live in the top level.

## Test plan
- Hold rst low, then release → theta1 = theta2 = 0 until edge 51; no X values on the outputs.
- x = 32768 (1.0), y = 0 → theta1 ≈ 0, theta2 ≈ 0.
- x = 0, y = 16384 (0.5) → theta2 ≈ 68629 (2π/3), theta1 ≈ 17157 (π/6); swap the sign of y → theta1 ≈ −85786.
- x = y = 16384 → theta2 ≈ 51472 (π/2), theta1 ≈ 0; with INV_KIN_ELBOW_UP_EN → theta2 ≈ −51472, theta1 ≈ 51472.
- x = −32768, y = 0 → theta1 ≈ 102944 (π), theta2 ≈ 0.
- x = 65536 (2.0, unreachable) → theta1 ≈ 0, theta2 = 0.
- Random 32-bit x, y every 500 cycles → all outputs within tolerance.
- Assert rst mid-VEC2 → outputs return to 0.
